// File: rtl/cl_word_unpacker.sv
// cl_word_unpacker: buffers 512-bit cache lines and replays them as WORD_W-bit words, LSB word first
module cl_word_unpacker #(
  parameter int WORD_W     = 64,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cl_valid,
  input  logic [511:0]      cl_data,
  output logic              cl_ready,
  output logic              word_valid,
  output logic [WORD_W-1:0] word_data,
  output logic              word_last,
  input  logic              word_ready,
  output logic [31:0]       lines_done,
  output logic              busy
);
  localparam int NWORDS = 512 / WORD_W;
  localparam int IW     = $clog2(NWORDS);
  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int CW     = PW + 1;
  typedef enum logic {S_IDLE, S_EMIT} state_t;
  state_t                          state_q, state_d;
  logic [PW-1:0]                   wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]                   cnt_q, cnt_d;
  logic [IW-1:0]                   idx_q, idx_d;
  logic [31:0]                     lines_done_q;
  logic                            rdy_q;
  logic [NWORDS-1:0][WORD_W-1:0]   mem_q [FIFO_DEPTH];
  logic                            push, xfer, at_last, pop;
  assign cl_ready   = rdy_q && (cnt_q < CW'(FIFO_DEPTH));
  assign word_valid = state_q == S_EMIT;
  assign at_last    = idx_q == IW'(NWORDS - 1);
  assign word_last  = word_valid && at_last;
  assign word_data  = mem_q[rd_q][idx_q];
  assign push       = cl_valid && cl_ready;
  assign xfer       = word_valid && word_ready;
  assign pop        = xfer && at_last;
  assign lines_done = lines_done_q;
  assign busy       = (cnt_q != '0) || (state_q == S_EMIT);
  // next-state: pointers, occupancy, word index and serializer state
  always_comb begin
    wr_d    = push ? wr_q + PW'(1) : wr_q;
    rd_d    = pop ? rd_q + PW'(1) : rd_q;
    cnt_d   = cnt_q + CW'(push) - CW'(pop);
    idx_d   = xfer ? (at_last ? '0 : idx_q + IW'(1)) : idx_q;
    state_d = state_q;
    if (state_q == S_IDLE) state_d = (cnt_q != '0) ? S_EMIT : S_IDLE;
    else if (pop) state_d = (cnt_d != '0) ? S_EMIT : S_IDLE;
  end
  // control state; cl_ready opens one edge after reset release via rdy_q
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      wr_q         <= '0;
      rd_q         <= '0;
      cnt_q        <= '0;
      idx_q        <= '0;
      lines_done_q <= '0;
      rdy_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rdy_q   <= 1'b1;
      if (pop) lines_done_q <= lines_done_q + 32'd1;
    end
  end
  // line payload storage, deliberately left unreset
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= cl_data;
  end
endmodule

// File: tb/tb_cl_word_unpacker.sv
// tb_cl_word_unpacker: directed scenarios with random lines checked against a queue-of-lines model
module tb_cl_word_unpacker;
  localparam int W = 64;
  localparam int D = 2;
  localparam int N = 512 / W;
  logic clk = 0, reset = 0, cl_valid = 0, word_ready = 0;
  logic [511:0] cl_data = '0;
  logic cl_ready, word_valid, word_last, busy;
  logic [W-1:0] word_data;
  logic [31:0] lines_done;
  always #5 clk = ~clk;
  cl_word_unpacker #(.WORD_W(W), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .cl_valid(cl_valid), .cl_data(cl_data), .cl_ready(cl_ready),
    .word_valid(word_valid), .word_data(word_data), .word_last(word_last), .word_ready(word_ready),
    .lines_done(lines_done), .busy(busy)
  );
  int checks = 0, passes = 0, exp_idx = 0, edges = 0;
  logic [511:0] mq[$];
  logic [31:0] done_m = 0;
  bit stall_prev = 0, pushed = 0, xfered = 0;
  task automatic chk(string tag, logic [511:0] obs, logic [511:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  function automatic logic [511:0] rline();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction
  function automatic logic [W-1:0] mword(logic [511:0] l, int k);
    return l[k*W +: W];
  endfunction
  task automatic cyc();
    #1;
    if (word_valid) begin
      chk("spurious_valid", mq.size() != 0, 1);
      if (mq.size() != 0) begin
        chk("word_data", word_data, mword(mq[0], exp_idx));
        chk("word_last", word_last, exp_idx == N - 1);
      end
    end else chk("word_last_idle", word_last, 0);
    if (stall_prev) chk("stall_hold_valid", word_valid, 1);
    chk("cl_ready", cl_ready, mq.size() < D);
    chk("busy", busy, mq.size() != 0);
    chk("lines_done", lines_done, done_m);
    pushed = cl_valid && cl_ready;
    xfered = word_valid && word_ready;
    stall_prev = word_valid && !word_ready;
    if (xfered && mq.size() != 0) begin
      if (exp_idx == N - 1) begin
        void'(mq.pop_front());
        exp_idx = 0;
        done_m++;
      end else exp_idx++;
    end
    if (pushed) mq.push_back(cl_data);
    @(posedge clk);
    edges++;
    #1;
  endtask
  task automatic drain(string tag, int lim);
    for (int n = 0; n < lim && mq.size() != 0; n++) cyc();
    chk(tag, mq.size(), 0);
  endtask
  initial begin
    logic [511:0] l, l0, l1, l2;
    int sent, t0, tf, tl, nx, db;
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cl_ready", cl_ready, 0);
    chk("rst_word_valid", word_valid, 0);
    chk("rst_word_last", word_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_lines_done", lines_done, 0);
    reset = 1;
    #1;
    chk("cl_ready_pre_edge", cl_ready, 0);
    @(posedge clk);
    #1;
    chk("cl_ready_after_release", cl_ready, 1);
    // single line, word k = 0x1000+k
    for (int k = 0; k < N; k++) l[k*W +: W] = W'(64'h1000 + k);
    cl_data = l;
    cl_valid = 1;
    cyc();
    cl_valid = 0;
    word_ready = 1;
    chk("lat_not_yet", word_valid, 0);
    cyc();
    chk("lat_valid", word_valid, 1);
    chk("first_word", word_data, 64'h1000);
    for (int k = 0; k < N; k++) begin
      cyc();
      chk("consecutive_xfer", xfered, 1);
    end
    chk("single_lines_done", lines_done, 1);
    chk("single_busy_after", busy, 0);
    chk("single_valid_after", word_valid, 0);
    // backpressure 1,0,0 pattern
    cl_data = rline();
    cl_valid = 1;
    word_ready = 0;
    cyc();
    cl_valid = 0;
    for (int n = 0; n < 100 && mq.size() != 0; n++) begin
      word_ready = (n % 3 == 0);
      cyc();
    end
    chk("bp_drained", mq.size(), 0);
    chk("bp_lines_done", lines_done, 2);
    // full FIFO with junk offered while stalled
    l0 = rline(); l1 = rline(); l2 = rline();
    word_ready = 0;
    cl_valid = 1;
    cl_data = l0;
    cyc();
    cl_data = l1;
    cyc();
    chk("full_cl_ready", cl_ready, 0);
    chk("full_occupancy", mq.size(), 2);
    repeat (4) begin
      cl_data = rline();
      cyc();
    end
    chk("full_hold", mq.size(), 2);
    cl_data = l2;
    word_ready = 1;
    for (int n = 0; n < 60 && (cl_valid || mq.size() != 0); n++) begin
      db = done_m;
      cyc();
      if (pushed) begin
        chk("third_after_pop", db, 3);
        cl_valid = 0;
      end
    end
    chk("full_drained", mq.size(), 0);
    chk("full_lines_done", lines_done, 5);
    // streaming four lines
    sent = 0; t0 = -1; tf = -1; tl = -1; nx = 0;
    cl_data = rline();
    cl_valid = 1;
    for (int n = 0; n < 80 && nx < 32; n++) begin
      cyc();
      if (xfered) begin
        if (tf < 0) tf = edges;
        tl = edges;
        nx++;
      end
      if (pushed) begin
        if (t0 < 0) t0 = edges;
        sent++;
        if (sent == 4) cl_valid = 0;
        else cl_data = rline();
      end
    end
    chk("stream_words", nx, 32);
    chk("stream_span", tl - t0, 33);
    chk("stream_gapless", tl - tf, 31);
    chk("stream_lines_done", lines_done, 9);
    // mid-line reset after word 3
    cl_data = rline();
    cl_valid = 1;
    cyc();
    cl_valid = 0;
    for (int n = 0; n < 20 && exp_idx < 4; n++) cyc();
    chk("mid_idx", exp_idx, 4);
    reset = 0;
    #1;
    chk("mid_rst_valid", word_valid, 0);
    chk("mid_rst_last", word_last, 0);
    chk("mid_rst_lines_done", lines_done, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cl_ready", cl_ready, 0);
    mq.delete();
    exp_idx = 0;
    done_m = 0;
    stall_prev = 0;
    @(posedge clk);
    #1;
    reset = 1;
    @(posedge clk);
    #1;
    chk("mid_rel_cl_ready", cl_ready, 1);
    l = rline();
    cl_data = l;
    cl_valid = 1;
    cyc();
    cl_valid = 0;
    cyc();
    chk("post_rst_valid", word_valid, 1);
    chk("post_rst_word0", word_data, mword(l, 0));
    drain("post_rst_drain", 20);
    chk("post_rst_lines_done", lines_done, 1);
    // lines_done wrap
    force dut.lines_done_q = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    release dut.lines_done_q;
    done_m = 32'hFFFF_FFFF;
    #1;
    chk("wrap_preset", lines_done, 32'hFFFF_FFFF);
    cl_data = rline();
    cl_valid = 1;
    cyc();
    cl_valid = 0;
    drain("wrap_drain", 20);
    chk("wrap_zero", lines_done, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/cl_word_unpacker.md
CL_WORD_UNPACKER -- requirements
Module: cl_word_unpacker

Interface
REQ-001 SHALL have parameter WORD_W, default 64, meaning output word width in bits; legal values 32, 64, 128, 256.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, meaning number of 512-bit line slots; legal values 2 or 4.
REQ-003 SHALL have derived constant NWORDS = 512/WORD_W, meaning words per cache line.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, meaning the reset; asynchronous assert, active-low (0 = in reset).
REQ-006 SHALL have port cl_valid, input, 1, meaning a cache line from the host read-response path is offered.
REQ-007 SHALL have port cl_data, input, 512, meaning cache-line payload; bytes 0..63 map to bits [7:0]..[511:504].
REQ-008 SHALL have port cl_ready, output, 1, meaning a slot is free; a line is accepted when cl_valid and cl_ready are both 1.
REQ-009 SHALL have port word_valid, output, 1, meaning word_data holds a valid word for the DUT.
REQ-010 SHALL have port word_data, output, WORD_W, meaning the current word.
REQ-011 SHALL have port word_last, output, 1, meaning the current word is the final word of its line.
REQ-012 SHALL have port word_ready, input, 1, meaning the DUT consumes the word; transfer occurs when word_valid and word_ready are both 1.
REQ-013 SHALL have port lines_done, output, 32, meaning count of lines fully emitted.
REQ-014 SHALL have port busy, output, 1, meaning at least one line is buffered or partially emitted.

Function
REQ-015 SHALL store accepted lines in a FIFO of FIFO_DEPTH slots, with write pointer, read pointer and occupancy count (0..FIFO_DEPTH).
REQ-016 SHALL drive cl_ready = 1 iff occupancy < FIFO_DEPTH; cl_ready SHALL be registered-state-derived only, with no combinational path from word_ready.
REQ-017 SHALL run a two-state serializer: S_IDLE and S_EMIT.
REQ-018 In S_IDLE with occupancy > 0, SHALL go to S_EMIT next cycle with word index = 0; word_valid SHALL be 0 in S_IDLE.
REQ-019 In S_EMIT, SHALL drive word_valid = 1 and word_data = head line bits [idx*WORD_W +: WORD_W], with word 0 = least significant bits.
REQ-020 In S_EMIT, SHALL drive word_last = 1 iff idx == NWORDS-1.
REQ-021 On each word transfer with idx < NWORDS-1, SHALL increment idx by 1.
REQ-022 On a transfer with idx == NWORDS-1, SHALL pop the head slot, set idx = 0, and increment lines_done.
REQ-023 After that pop, SHALL stay in S_EMIT if another line remains after the pop, else go to S_IDLE.
REQ-024 With word_valid = 1 and word_ready = 0, SHALL hold word_data, word_last and idx stable.
REQ-025 Simultaneous accept and final-word pop in one cycle SHALL leave occupancy unchanged and advance both pointers.
REQ-026 An accept while occupancy == FIFO_DEPTH is impossible, because cl_ready = 0; cl_data SHALL be ignored whenever cl_ready = 0.
REQ-027 Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 lines_done SHALL wrap from 0xFFFFFFFF to 0.
REQ-029 busy SHALL equal (occupancy != 0) OR (state == S_EMIT).
REQ-030 Latency SHALL be: a line accepted at edge N into an empty block gives word_valid = 1 after edge N+1.
REQ-031 With word_ready held 1, SHALL emit one word per cycle with no bubbles between back-to-back lines.

Reset
REQ-032 While reset = 0, SHALL force state = S_IDLE, occupancy = 0, pointers = 0, idx = 0, lines_done = 0.
REQ-033 While reset = 0, SHALL force word_valid = 0, word_last = 0, busy = 0 and cl_ready = 0.
REQ-034 FIFO payload storage SHALL not be reset.
REQ-035 Reset asserted mid-line SHALL discard all buffered and partially emitted data.
REQ-036 After reset deasserts, SHALL take cl_ready = 1 on the first rising edge.

Verification
REQ-037 Scenario single line: WORD_W = 64, one line with word k = 64'h1000+k, word_ready = 1 -> 8 words 0x1000..0x1007 on consecutive cycles; word_last only on 0x1007; lines_done = 1; busy = 0 afterwards.
REQ-038 Scenario backpressure: word_ready toggles 1,0,0,1,... -> no word duplicated or skipped, and word_data is stable during stalls.
REQ-039 Scenario full: FIFO_DEPTH = 2, word_ready = 0, three lines offered -> two accepted and cl_ready = 0; the third is accepted only after the first line's word 7 transfers.
REQ-040 Scenario streaming: 4 lines back-to-back with word_ready = 1 -> 32 words in 33 cycles from the first accept with no gaps; lines_done = 4.
REQ-041 Scenario mid-line reset: reset = 0 after word 3 of a line -> word_valid = 0 immediately and lines_done = 0; after release a new line emits from word 0.
REQ-042 Scenario counter wrap: lines_done preset through a forced force/deposit to 0xFFFFFFFF, then one line completes -> lines_done = 0.
